arb_nbit_lock: RTL and testbench
================================

Name: arb_nbit_lock

Overview:
- Parametrised N-requester arbiter; successor to the team's fixed-priority N-bit arbiter.
- Adds a run-time mode select (fixed priority or round-robin) and a registered grant that stays locked to the winner while its request remains asserted.
- Adds a MAX_HOLD burst limit so a locked holder cannot starve other requesters.
- Sits in front of shared resources (bus, memory port, FIFO write side). Consumers observe only the registered grant.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay locked; 0 = unlimited.
- IDXW, $clog2(N), width of the grant index (derived, not overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- i_request  input  N  per-requester request level.
- o_grant  output  N  one-hot registered grant; all zero when idle.
- o_grant_valid  output  1  high while any grant bit is set.
- o_grant_idx  output  IDXW  binary index of the granted requester; 0 when idle.

Behaviour:
- Reset: asserting i_rst_n low immediately clears o_grant=0, o_grant_valid=0, o_grant_idx=0, the RR pointer (ptr=0), the hold counter (cnt=0) and state=IDLE. This is asynchronous. Release is synchronous to i_clk.
- All outputs are registered. A request sampled at edge k produces a grant visible after edge k (one-cycle latency). No combinational path exists from i_request to the outputs.
- FSM states:
  - IDLE:
    - If any i_request bit is set, arbitrate, load the winner into o_grant, set cnt=1 and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT (holder h):
    - Release condition: i_request[h]==0, or (MAX_HOLD!=0 and cnt==MAX_HOLD).
    - If the release condition is false, hold the grant and increment cnt (saturating).
    - On release, arbitrate in the same edge. A winner gives a back-to-back grant with no idle bubble and cnt=1. No eligible request sends the FSM to IDLE with the grant cleared.
- Eligibility: on a timeout release, h is excluded from that single arbitration. On a drop release, the eligible set is simply the requests currently asserted.
  - If h is the only requester at timeout, the FSM goes to IDLE for one cycle, then re-grants h.
- Fixed mode: the highest set eligible index wins.
- Round-robin mode:
  - Search eligible requests ascending and circularly from ptr; the first set index wins.
  - On every new grant to w, ptr <= (w+1) mod N. ptr is not updated in fixed mode.
- i_mode is sampled only at arbitration points. Changing it mid-grant does not disturb the current holder.
- Invariant: o_grant is always zero or one-hot.
- Invariant: o_grant_valid == |o_grant, and o_grant_idx matches o_grant.
- Requests asserted and dropped between arbitration points while another holder is locked are not remembered. Requests are level-sensitive.

Test Plan:
- Reset: drive i_rst_n=0 mid-cycle with i_request=4'b1111 -> outputs go to 0 immediately without a clock edge. After release with no requests, outputs stay at 0.
- Fixed priority (N=4, i_mode=0): i_request=4'b0110 held -> after 1 edge o_grant=4'b0100, idx=2, valid=1. Drop bit 2 -> next edge o_grant=4'b0010 (no bubble). Drop all -> next edge o_grant=0.
- Round-robin with MAX_HOLD=1 (i_mode=1): i_request=4'b1111 constant from reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive edges.
- Timeout (MAX_HOLD=4, i_mode=0): i_request=4'b1001 constant -> 1000 for 4 cycles, then 0001 for 4 cycles, then 1000 again. No cycle has o_grant=0.
- Sole requester timeout (MAX_HOLD=4): i_request=4'b0100 constant -> 0100 for 4 cycles, 0000 for 1 cycle, then 0100 again.
- Mode switch and reset mid-grant: switch i_mode 0->1 while 4'b0100 is locked -> grant unchanged until release. Assert i_rst_n=0 while granted -> outputs clear at once, ptr=0, and after release the first RR grant starts its search from index 0.

Source files
------------

// File: rtl/arb_nbit_lock.sv
// N-requester arbiter with fixed/round-robin mode select and a registered,
// locked grant that is released on request drop or after MAX_HOLD cycles.
module arb_nbit_lock #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDXW     = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mode,
    input  logic [N-1:0]    i_request,
    output logic [N-1:0]    o_grant,
    output logic            o_grant_valid,
    output logic [IDXW-1:0] o_grant_idx
);

    localparam int CNTW = $clog2(MAX_HOLD + 2);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;

    logic            timeout;
    logic            drop;
    logic            arb;
    logic [N-1:0]    elig;
    logic            win_found;
    logic [IDXW-1:0] win_idx;

    assign timeout = (state_q == S_GRANT) && (MAX_HOLD != 0)
                     && (cnt_q == CNTW'(MAX_HOLD));
    assign drop    = (state_q == S_GRANT) && !i_request[idx_q];
    assign arb     = (state_q == S_IDLE) || drop || timeout;

    // A timed-out holder sits out exactly one arbitration.
    always_comb begin
        elig = i_request;
        if (timeout) begin
            elig[idx_q] = 1'b0;
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (!i_mode) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDXW'(i);
                end
            end
        end else begin
            // Walk offsets downward so the nearest one after ptr wins last.
            for (int k = N - 1; k >= 0; k--) begin
                if (elig[(int'(ptr_q) + k) % N]) begin
                    win_found = 1'b1;
                    win_idx   = IDXW'((int'(ptr_q) + k) % N);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (arb) begin
            if (win_found) begin
                state_d = S_GRANT;
                grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                idx_d   = win_idx;
                cnt_d   = CNTW'(1);
                valid_d = 1'b1;
                if (i_mode) begin
                    ptr_d = IDXW'((int'(win_idx) + 1) % N);
                end
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_valid = valid_q;
    assign o_grant_idx   = idx_q;

endmodule

// File: tb/tb_arb_nbit_lock.sv
// Bench for arb_nbit_lock: three instances (MAX_HOLD 8/1/4) share stimulus
// and are compared against a request-list reference model every cycle.
module tb_arb_nbit_lock;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [N-1:0] req;

    logic [N-1:0] g0, g1, g2;
    logic [1:0]   gi0, gi1, gi2;
    logic         gv0, gv1, gv2;

    int total = 0;
    int bad   = 0;

    int maxh[3] = '{8, 1, 4};
    int m_hold[3];
    int m_cnt[3];
    int m_ptr[3];

    arb_nbit_lock #(.N(N), .MAX_HOLD(8)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_request(req),
        .o_grant(g0), .o_grant_valid(gv0), .o_grant_idx(gi0)
    );

    arb_nbit_lock #(.N(N), .MAX_HOLD(1)) u_h1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_request(req),
        .o_grant(g1), .o_grant_valid(gv1), .o_grant_idx(gi1)
    );

    arb_nbit_lock #(.N(N), .MAX_HOLD(4)) u_h4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_request(req),
        .o_grant(g2), .o_grant_valid(gv2), .o_grant_idx(gi2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_hold[m] = -1;
            m_cnt[m]  = 0;
            m_ptr[m]  = 0;
        end
    endtask

    // Holder is an integer index (-1 = nobody); arbitration scans a list.
    task automatic model_step(input logic [N-1:0] r, input logic md);
        for (int m = 0; m < 3; m++) begin
            int  h;
            bit  tmo;
            bit  rel;
            int  w;
            int  cand[$];
            h   = m_hold[m];
            tmo = (h >= 0) && (maxh[m] != 0) && (m_cnt[m] == maxh[m]);
            rel = (h < 0) || !r[h] || tmo;
            if (!rel) begin
                m_cnt[m]++;
                continue;
            end
            cand.delete();
            if (md) begin
                for (int k = 0; k < N; k++) cand.push_back((m_ptr[m] + k) % N);
            end else begin
                for (int k = N - 1; k >= 0; k--) cand.push_back(k);
            end
            w = -1;
            foreach (cand[c]) begin
                if (w < 0 && r[cand[c]] && !(tmo && cand[c] == h)) w = cand[c];
            end
            m_hold[m] = w;
            m_cnt[m]  = (w < 0) ? 0 : 1;
            if (md && w >= 0) m_ptr[m] = (w + 1) % N;
        end
    endtask

    task automatic check_models();
        logic [N-1:0] gg[3];
        logic [1:0]   ii[3];
        logic         vv[3];
        gg = '{g0, g1, g2};
        ii = '{gi0, gi1, gi2};
        vv = '{gv0, gv1, gv2};
        for (int m = 0; m < 3; m++) begin
            int h;
            h = m_hold[m];
            chk($sformatf("dut%0d grant", m), gg[m], (h < 0) ? 0 : (1 << h));
            chk($sformatf("dut%0d idx", m), ii[m], (h < 0) ? 0 : h);
            chk($sformatf("dut%0d valid", m), vv[m], (h < 0) ? 0 : 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(req, mode);
        #1;
        check_models();
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async g0", g0, 0);
        chk("async g1", g1, 0);
        chk("async g2", g2, 0);
        chk("async v0", gv0, 0);
        check_models();
    endtask

    task automatic release_rst();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_rr[5];
        logic [N-1:0] exp_to[9];
        logic [N-1:0] exp_sole[6];
        exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_to   = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                     4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
        exp_sole = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};

        rst_n = 1'b1;
        mode  = 1'b0;
        req   = '0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset grant", g0, 0);
        chk("reset idx", gi0, 0);
        chk("reset valid", gv0, 0);
        #10;
        rst_n = 1'b1;
        tick();

        req = 4'b0110;
        tick();
        chk("fix grant", g0, 4'b0100);
        chk("fix idx", gi0, 2);
        chk("fix valid", gv0, 1);
        req = 4'b0010;
        tick();
        chk("fix b2b", g0, 4'b0010);
        req = 4'b0000;
        tick();
        chk("fix idle", g0, 4'b0000);

        async_reset();
        mode = 1'b1;
        req  = 4'b1111;
        release_rst();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d", i), g1, exp_rr[i]);
        end

        async_reset();
        req = 4'b0000;
        release_rst();
        tick();
        tick();
        chk("post-rst idle", g0, 0);
        chk("post-rst idle v", gv0, 0);

        async_reset();
        mode = 1'b0;
        req  = 4'b1001;
        release_rst();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("tmo%0d", i), g2, exp_to[i]);
        end

        async_reset();
        req = 4'b0100;
        release_rst();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sole%0d", i), g2, exp_sole[i]);
        end

        async_reset();
        mode = 1'b1;
        req  = 4'b0100;
        release_rst();
        tick();
        req = 4'b0000;
        tick();
        mode = 1'b0;
        req  = 4'b0100;
        tick();
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("modesw%0d", i), g0, 4'b0100);
        end
        async_reset();
        req = 4'b1010;
        release_rst();
        tick();
        chk("rr ptr cleared", g0, 4'b0010);

        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
                release_rst();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
